// File: rtl/tetris_pkg.sv
// Shared playfield constants, key indices and scheduler state encoding for the
// falling-piece logic.
package tetris_pkg;
  localparam int GRID_W_DEF = 8;
  localparam int GRID_H_DEF = 18;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_SEL        = 4'd1;
  localparam logic [3:0] ST_CHK_REQ    = 4'd2;
  localparam logic [3:0] ST_CHK_WAIT   = 4'd3;
  localparam logic [3:0] ST_COMMIT     = 4'd4;
  localparam logic [3:0] ST_LOCK       = 4'd5;
  localparam logic [3:0] ST_SPAWN_REQ  = 4'd6;
  localparam logic [3:0] ST_SPAWN_WAIT = 4'd7;
  localparam logic [3:0] ST_OVER       = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE       = ST_IDLE,
    S_SEL        = ST_SEL,
    S_CHK_REQ    = ST_CHK_REQ,
    S_CHK_WAIT   = ST_CHK_WAIT,
    S_COMMIT     = ST_COMMIT,
    S_LOCK       = ST_LOCK,
    S_SPAWN_REQ  = ST_SPAWN_REQ,
    S_SPAWN_WAIT = ST_SPAWN_WAIT,
    S_OVER       = ST_OVER
  } sched_state_e;

  typedef enum logic [2:0] {MV_UP, MV_DOWN, MV_LEFT, MV_RIGHT, MV_GRAV} move_e;

  // Vertical moves lock the piece when blocked; sideways moves just give up.
  function automatic logic is_vert(move_e m);
    return (m == MV_UP) || (m == MV_DOWN) || (m == MV_GRAV);
  endfunction
endpackage

// File: rtl/key_latch.sv
// Rising-edge detect on the operator keys; each edge raises a pending flag
// that stays up until the scheduler services that key.
module key_latch #(
  parameter int N = 4
) (
  input  logic         vga_clk,
  input  logic         rst,
  input  logic [N-1:0] keys,
  input  logic [N-1:0] clr,
  output logic [N-1:0] pend
);
  logic [N-1:0] keys_q;

  // A fresh edge wins over a same-cycle clear so no press is lost.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      keys_q <= '0;
      pend   <= '0;
    end else begin
      keys_q <= keys;
      pend   <= (pend & ~clr) | (keys & ~keys_q);
    end
  end
endmodule

// File: rtl/piece_move_sched.sv
// Per-frame move scheduler for the single-cell falling piece: key phase, then
// gravity, each move checked against grid memory; locks, respawns, game over.
module piece_move_sched
  import tetris_pkg::*;
#(
  parameter int GRID_W         = GRID_W_DEF,
  parameter int GRID_H         = GRID_H_DEF,
  parameter int GRAVITY_FRAMES = 30,
  parameter int SPAWN_X        = 3
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic [3:0] op_keys,
  input  logic       draw_finish,
  output logic [7:0] grid_rd_x,
  output logic [7:0] grid_rd_y,
  input  logic       grid_rd_data,
  output logic       grid_wr_en,
  output logic [7:0] grid_wr_x,
  output logic [7:0] grid_wr_y,
  output logic [7:0] piece_x,
  output logic [7:0] piece_y,
  output logic       busy,
  output logic       game_over
);
  localparam int            CW       = $clog2(GRAVITY_FRAMES + 1);
  localparam logic [7:0]    LAST_X   = 8'(GRID_W - 1);
  localparam logic [7:0]    LAST_Y   = 8'(GRID_H - 1);
  localparam logic [7:0]    SPX      = 8'(SPAWN_X);
  localparam logic [CW-1:0] GRAV_TOP = CW'(GRAVITY_FRAMES - 1);

  sched_state_e  state;
  move_e         mv, key_mv, sel_mv;
  logic [3:0]    pend, key_clr;
  logic [7:0]    tgt_x, tgt_y, sel_x, sel_y;
  logic [CW-1:0] grav_cnt;
  logic          df_q, tick, key_done, grav_due, tgt_oob;
  logic          key_any, sel_go, sel_oob;

  key_latch #(.N(4)) u_key_latch (
    .vga_clk (vga_clk),
    .rst     (rst),
    .keys    (op_keys),
    .clr     (key_clr),
    .pend    (pend)
  );

  assign tick = draw_finish & ~df_q;
  assign busy = (state != S_IDLE);

  // Target selection: one key (up>down>left>right) per pass, else gravity.
  always_comb begin
    key_any = |pend;
    key_mv  = MV_RIGHT;
    key_clr = 4'b0000;
    if (pend[KEY_UP])        key_mv = MV_UP;
    else if (pend[KEY_DOWN]) key_mv = MV_DOWN;
    else if (pend[KEY_LEFT]) key_mv = MV_LEFT;

    sel_go = 1'b1;
    sel_mv = MV_GRAV;
    if (!key_done && key_any) sel_mv = key_mv;
    else if (!grav_due)       sel_go = 1'b0;

    if (state == S_SEL && !key_done && key_any) begin
      case (key_mv)
        MV_UP:   key_clr = 4'b0001 << KEY_UP;
        MV_DOWN: key_clr = 4'b0001 << KEY_DOWN;
        MV_LEFT: key_clr = 4'b0001 << KEY_LEFT;
        default: key_clr = 4'b0001 << KEY_RIGHT;
      endcase
    end

    sel_x   = piece_x;
    sel_y   = piece_y;
    sel_oob = 1'b0;
    case (sel_mv)
      MV_LEFT: begin
        sel_x   = piece_x - 8'd1;
        sel_oob = (piece_x == 8'd0);
      end
      MV_RIGHT: begin
        sel_x   = piece_x + 8'd1;
        sel_oob = (piece_x >= LAST_X);
      end
      default: begin
        sel_y   = piece_y + 8'd1;
        sel_oob = (piece_y >= LAST_Y);
      end
    endcase
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mv         <= MV_GRAV;
      df_q       <= 1'b0;
      key_done   <= 1'b0;
      grav_due   <= 1'b0;
      grav_cnt   <= '0;
      tgt_x      <= 8'd0;
      tgt_y      <= 8'd0;
      tgt_oob    <= 1'b0;
      piece_x    <= SPX;
      piece_y    <= 8'd0;
      grid_rd_x  <= 8'd0;
      grid_rd_y  <= 8'd0;
      grid_wr_en <= 1'b0;
      grid_wr_x  <= 8'd0;
      grid_wr_y  <= 8'd0;
      game_over  <= 1'b0;
    end else begin
      df_q       <= draw_finish;
      grid_wr_en <= 1'b0;
      case (state)
        S_IDLE: if (tick) begin
          state    <= S_SEL;
          key_done <= 1'b0;
          grav_due <= (grav_cnt == GRAV_TOP);
          grav_cnt <= grav_cnt + CW'(1);
        end
        S_SEL: begin
          key_done <= 1'b1;
          if (!sel_go) state <= S_IDLE;
          else begin
            mv      <= sel_mv;
            tgt_x   <= sel_x;
            tgt_y   <= sel_y;
            tgt_oob <= sel_oob;
            if (!sel_oob) begin
              grid_rd_x <= sel_x;
              grid_rd_y <= sel_y;
            end
            if (is_vert(sel_mv))    grav_cnt <= '0;
            if (sel_mv == MV_GRAV) grav_due <= 1'b0;
            state <= S_CHK_REQ;
          end
        end
        // Off-grid targets never touch memory.
        S_CHK_REQ: begin
          if (tgt_oob) state <= is_vert(mv) ? S_LOCK : S_SEL;
          else         state <= S_CHK_WAIT;
        end
        S_CHK_WAIT: begin
          if (grid_rd_data) state <= is_vert(mv) ? S_LOCK : S_SEL;
          else              state <= S_COMMIT;
        end
        S_COMMIT: begin
          piece_x <= tgt_x;
          piece_y <= tgt_y;
          if (mv == MV_UP) begin
            tgt_y   <= tgt_y + 8'd1;
            tgt_oob <= (tgt_y >= LAST_Y);
            if (tgt_y < LAST_Y) begin
              grid_rd_x <= tgt_x;
              grid_rd_y <= tgt_y + 8'd1;
            end
            state <= S_CHK_REQ;
          end else begin
            state <= (mv == MV_GRAV) ? S_IDLE : S_SEL;
          end
        end
        S_LOCK: begin
          grid_wr_en <= 1'b1;
          grid_wr_x  <= piece_x;
          grid_wr_y  <= piece_y;
          piece_x    <= SPX;
          piece_y    <= 8'd0;
          grid_rd_x  <= SPX;
          grid_rd_y  <= 8'd0;
          state      <= S_SPAWN_REQ;
        end
        S_SPAWN_REQ: state <= S_SPAWN_WAIT;
        S_SPAWN_WAIT: begin
          if (grid_rd_data) begin
            game_over <= 1'b1;
            state     <= S_OVER;
          end else begin
            state <= S_IDLE;
          end
        end
        S_OVER:  state <= S_OVER;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piece_move_sched.sv
// Bench for piece_move_sched: table of per-frame stimuli with hand-derived
// expected piece/grid results, plus latency and mid-pass reset sequences.
module tb_piece_move_sched;
  localparam int GRID_W = 8;
  localparam int GRID_H = 18;
  localparam int GF     = 3;
  localparam int SPAWN_X = 3;

  logic       vga_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] op_keys = 4'b0000;
  logic       draw_finish = 1'b0;
  logic [7:0] grid_rd_x, grid_rd_y, grid_wr_x, grid_wr_y, piece_x, piece_y;
  logic       grid_rd_data = 1'b0;
  logic       grid_wr_en, busy, game_over;

  piece_move_sched #(.GRID_W(GRID_W), .GRID_H(GRID_H), .GRAVITY_FRAMES(GF), .SPAWN_X(SPAWN_X)) dut (
    .vga_clk      (vga_clk),
    .rst          (rst),
    .op_keys      (op_keys),
    .draw_finish  (draw_finish),
    .grid_rd_x    (grid_rd_x),
    .grid_rd_y    (grid_rd_y),
    .grid_rd_data (grid_rd_data),
    .grid_wr_en   (grid_wr_en),
    .grid_wr_x    (grid_wr_x),
    .grid_wr_y    (grid_wr_y),
    .piece_x      (piece_x),
    .piece_y      (piece_y),
    .busy         (busy),
    .game_over    (game_over)
  );

  always #5 vga_clk = ~vga_clk;

  // Grid memory: synchronous read, data one cycle after address.
  logic [GRID_W*GRID_H-1:0] grid = '0;
  logic       mem_clr = 1'b0, mem_set = 1'b0;
  logic [7:0] set_x = 8'd0, set_y = 8'd0;
  int         wr_total = 0;
  logic [7:0] last_wx = 8'd0, last_wy = 8'd0;

  always @(posedge vga_clk) begin
    if (mem_clr) grid <= '0;
    else begin
      if (grid_wr_en && grid_wr_x < GRID_W && grid_wr_y < GRID_H)
        grid[int'(grid_wr_y)*GRID_W + int'(grid_wr_x)] <= 1'b1;
      if (mem_set) grid[int'(set_y)*GRID_W + int'(set_x)] <= 1'b1;
    end
    if (grid_rd_x < GRID_W && grid_rd_y < GRID_H)
      grid_rd_data <= grid[int'(grid_rd_y)*GRID_W + int'(grid_rd_x)];
    else
      grid_rd_data <= 1'b1;
    if (grid_wr_en) begin
      wr_total <= wr_total + 1;
      last_wx  <= grid_wr_x;
      last_wy  <= grid_wr_y;
    end
  end

  typedef struct {
    logic [3:0] keys;
    int         extra;
    bit         occ;
    int         px, py;
    bit         wr;
    int         wx, wy;
    int         rx, ry;
    bit         go;
  } vec_t;

  vec_t tbl[22];
  vec_t sb[$];
  int   n_chk = 0, n_fail = 0;

  function automatic vec_t mk(logic [3:0] k, int ex, bit occ, int px, int py,
                              bit wr, int wx, int wy, int rx, int ry, bit go);
    vec_t v;
    v.keys = k; v.extra = ex; v.occ = occ; v.px = px; v.py = py;
    v.wr = wr; v.wx = wx; v.wy = wy; v.rx = rx; v.ry = ry; v.go = go;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int   base;
    bit   done;
    if (v.occ) begin
      mem_set = 1'b1; set_x = 8'(SPAWN_X); set_y = 8'd0;
      @(negedge vga_clk);
      mem_set = 1'b0;
    end
    base = wr_total;
    op_keys = v.keys;
    @(negedge vga_clk);
    op_keys = 4'b0000;
    @(negedge vga_clk);
    sb.push_back(v);
    draw_finish = 1'b1;
    @(negedge vga_clk);
    draw_finish = 1'b0;
    for (int k = 0; k < v.extra; k++) begin
      @(negedge vga_clk); draw_finish = 1'b1;
      @(negedge vga_clk); draw_finish = 1'b0;
    end
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge vga_clk);
      if (c >= 8 && (!busy || game_over)) begin done = 1'b1; break; end
    end
    e = sb.pop_front();
    chk($sformatf("v%0d pass_end", idx), int'(done), 1);
    chk($sformatf("v%0d piece_x", idx), int'(piece_x), e.px);
    chk($sformatf("v%0d piece_y", idx), int'(piece_y), e.py);
    chk($sformatf("v%0d grid_rd_x", idx), int'(grid_rd_x), e.rx);
    chk($sformatf("v%0d grid_rd_y", idx), int'(grid_rd_y), e.ry);
    chk($sformatf("v%0d game_over", idx), int'(game_over), int'(e.go));
    chk($sformatf("v%0d busy", idx), int'(busy), int'(e.go));
    chk($sformatf("v%0d wr_pulses", idx), wr_total - base, e.wr ? 1 : 0);
    if (e.wr) begin
      chk($sformatf("v%0d wr_x", idx), int'(last_wx), e.wx);
      chk($sformatf("v%0d wr_y", idx), int'(last_wy), e.wy);
    end
  endtask

  initial begin
    int base;
    //             keys     ex occ px py wr wx wy rx ry go
    tbl[0]  = mk(4'b1000, 0, 0, 4, 0,  0, 0, 0,  4, 0, 0); // right
    tbl[1]  = mk(4'b0000, 0, 0, 4, 0,  0, 0, 0,  4, 0, 0);
    tbl[2]  = mk(4'b0000, 0, 0, 4, 1,  0, 0, 0,  4, 1, 0); // gravity on 3rd tick
    tbl[3]  = mk(4'b0100, 0, 0, 3, 1,  0, 0, 0,  3, 1, 0);
    tbl[4]  = mk(4'b0010, 0, 0, 3, 2,  0, 0, 0,  3, 2, 0); // down clears counter
    tbl[5]  = mk(4'b1100, 0, 0, 2, 2,  0, 0, 0,  2, 2, 0); // left beats right
    tbl[6]  = mk(4'b0000, 0, 0, 3, 2,  0, 0, 0,  3, 2, 0); // right still pending
    tbl[7]  = mk(4'b0000, 0, 0, 3, 3,  0, 0, 0,  3, 3, 0);
    tbl[8]  = mk(4'b0100, 0, 0, 2, 3,  0, 0, 0,  2, 3, 0);
    tbl[9]  = mk(4'b0100, 0, 0, 1, 3,  0, 0, 0,  1, 3, 0);
    tbl[10] = mk(4'b0100, 0, 0, 0, 4,  0, 0, 0,  0, 4, 0); // key then gravity
    tbl[11] = mk(4'b0110, 0, 0, 0, 5,  0, 0, 0,  0, 5, 0); // down beats left
    tbl[12] = mk(4'b0000, 0, 0, 0, 5,  0, 0, 0,  0, 5, 0); // left at x=0: no read
    tbl[13] = mk(4'b0001, 0, 0, 3, 0,  1, 0, 17, 3, 0, 0); // hard drop col 0
    tbl[14] = mk(4'b0001, 0, 0, 3, 0,  1, 3, 17, 3, 0, 0); // hard drop col 3
    tbl[15] = mk(4'b0001, 2, 0, 3, 0,  1, 3, 16, 3, 0, 0); // busy ticks dropped
    tbl[16] = mk(4'b0000, 0, 0, 3, 0,  0, 0, 0,  3, 0, 0);
    tbl[17] = mk(4'b0000, 0, 0, 3, 0,  0, 0, 0,  3, 0, 0);
    tbl[18] = mk(4'b0000, 0, 0, 3, 1,  0, 0, 0,  3, 1, 0);
    tbl[19] = mk(4'b0001, 0, 1, 3, 0,  1, 3, 15, 3, 0, 1); // spawn blocked
    tbl[20] = mk(4'b1000, 0, 0, 3, 0,  0, 0, 0,  3, 0, 1); // ignored in OVER
    tbl[21] = mk(4'b0001, 0, 0, 3, 0,  0, 0, 0,  3, 0, 1);

    mem_clr = 1'b1;
    repeat (3) @(negedge vga_clk);
    chk("rst piece_x", int'(piece_x), SPAWN_X);
    chk("rst piece_y", int'(piece_y), 0);
    chk("rst grid_rd_x", int'(grid_rd_x), 0);
    chk("rst grid_rd_y", int'(grid_rd_y), 0);
    chk("rst grid_wr_en", int'(grid_wr_en), 0);
    chk("rst grid_wr_x", int'(grid_wr_x), 0);
    chk("rst grid_wr_y", int'(grid_wr_y), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst game_over", int'(game_over), 0);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge vga_clk);

    for (int i = 0; i < 22; i++) run_vec(i, tbl[i]);

    // Single free move lands on the 4th edge after the tick is taken.
    rst = 1'b1; mem_clr = 1'b1;
    repeat (2) @(negedge vga_clk);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge vga_clk);
    op_keys = 4'b1000;
    @(negedge vga_clk);
    op_keys = 4'b0000;
    @(negedge vga_clk);
    draw_finish = 1'b1;
    @(negedge vga_clk);
    draw_finish = 1'b0;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("lat before piece_x", int'(piece_x), 3);
    @(negedge vga_clk);
    chk("lat after piece_x", int'(piece_x), 4);
    repeat (4) @(negedge vga_clk);

    // Reset while a blocked down move sits in CHK_WAIT.
    mem_set = 1'b1; set_x = 8'd4; set_y = 8'd1;
    @(negedge vga_clk);
    mem_set = 1'b0;
    base = wr_total;
    op_keys = 4'b0010;
    @(negedge vga_clk);
    op_keys = 4'b0000;
    @(negedge vga_clk);
    draw_finish = 1'b1;
    @(negedge vga_clk);
    draw_finish = 1'b0;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("abort grid_rd_y", int'(grid_rd_y), 1);
    rst = 1'b1;
    repeat (3) @(negedge vga_clk);
    rst = 1'b0;
    repeat (6) @(negedge vga_clk);
    chk("abort wr_pulses", wr_total - base, 0);
    chk("abort piece_x", int'(piece_x), SPAWN_X);
    chk("abort piece_y", int'(piece_y), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort game_over", int'(game_over), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
